bank_response_reorder: RTL and testbench

- Return-path companion to the bank interleaver; sits between bank response arbitration and the SM load-return path.
- Hands out in-order tags to requests, accepts bank responses out of order, and rebuilds the linear address by inverting the (bank, row) mapping.
- Returns data to the requester strictly in tag-allocation order.

---
 rtl/bank_response_reorder.sv | 153 +++++++++++++++
 tb/tb_bank_response_reorder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_response_reorder.sv
// Reorder buffer for bank responses: hands out in-order tags, accepts completions out of order,
// rebuilds the linear address and retires strictly in tag order. Optional stats: BANK_RSP_STATS_EN.
module bank_response_reorder #(
  parameter int ADDR_WIDTH = 32,
  parameter int BANKS      = 8,
  parameter int SWIZZLE    = 1,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   alloc_valid,
  output logic                                   alloc_ready,
  output logic [$clog2(DEPTH)-1:0]               alloc_tag,
  input  logic                                   rsp_valid,
  input  logic [$clog2(DEPTH)-1:0]               rsp_tag,
  input  logic [$clog2(BANKS)-1:0]               rsp_bank,
  input  logic [ADDR_WIDTH-$clog2(BANKS)-1:0]    rsp_row,
  input  logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(DEPTH)-1:0]               out_tag,
  output logic [ADDR_WIDTH-1:0]                  out_addr,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic                                   err,
  output logic [31:0]                            stat_rsp_cnt,
  output logic [15:0]                            stat_err_cnt
);

  localparam int BANK_BITS = $clog2(BANKS);
  localparam int TAG_BITS  = $clog2(DEPTH);
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
  localparam logic [TAG_BITS:0]   FULL_CNT = (TAG_BITS+1)'(DEPTH);
  localparam logic [TAG_BITS:0]   CNT_ONE  = (TAG_BITS+1)'(1);
  localparam logic [TAG_BITS-1:0] PTR_ONE  = TAG_BITS'(1);

  // Inverse of the interleaver: the low address bits were XORed with the low row bits.
  function automatic logic [ADDR_WIDTH-1:0] f_rebuild_addr(
    input logic [BANK_BITS-1:0] bank,
    input logic [ROW_W-1:0]     row
  );
    logic [BANK_BITS-1:0] low;
    if (SWIZZLE != 0) begin
      low = bank ^ row[BANK_BITS-1:0];
    end else begin
      low = bank;
    end
    return {row, low};
  endfunction

  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      r_done;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [TAG_BITS-1:0]   r_wr_ptr;
  logic [TAG_BITS-1:0]   r_rd_ptr;
  logic [TAG_BITS:0]     r_count;
  logic                  r_err;

  logic                  w_alloc_fire;
  logic                  w_rsp_legal;
  logic                  w_rsp_illegal;
  logic                  w_retire;
  logic [ADDR_WIDTH-1:0] w_rsp_addr;

  // Pend is registered, so a tag granted this cycle still reads as not pending here.
  assign w_alloc_fire  = alloc_valid & alloc_ready;
  assign w_rsp_legal   = rsp_valid & r_pend[rsp_tag] & ~r_done[rsp_tag];
  assign w_rsp_illegal = rsp_valid & ~w_rsp_legal;
  assign w_retire      = out_valid & out_ready;
  assign w_rsp_addr    = f_rebuild_addr(rsp_bank, rsp_row);

  assign alloc_ready = (r_count < FULL_CNT);
  assign alloc_tag   = r_wr_ptr;
  assign out_valid   = r_done[r_rd_ptr];
  assign out_tag     = r_rd_ptr;
  assign out_addr    = r_addr[r_rd_ptr];
  assign out_data    = r_data[r_rd_ptr];
  assign err         = r_err;

  // Tag bookkeeping: pointers, occupancy, pend/done flags and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_done   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_alloc_fire) begin
        r_pend[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PTR_ONE;
      end
      if (w_rsp_legal) begin
        r_done[rsp_tag] <= 1'b1;
      end else if (w_rsp_illegal) begin
        r_err <= 1'b1;
      end
      // Head is done and alloc needs a free slot, so these indices never collide with the above.
      if (w_retire) begin
        r_pend[r_rd_ptr] <= 1'b0;
        r_done[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PTR_ONE;
      end
      case ({w_alloc_fire, w_retire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage, written only by legal responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_rsp_legal) begin
      r_addr[rsp_tag] <= w_rsp_addr;
      r_data[rsp_tag] <= rsp_data;
    end
  end

`ifdef BANK_RSP_STATS_EN
  logic [31:0] r_stat_rsp_cnt;
  logic [15:0] r_stat_err_cnt;

  // Retire count wraps; error count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_rsp_cnt <= 32'd0;
      r_stat_err_cnt <= 16'd0;
    end else begin
      if (w_retire) begin
        r_stat_rsp_cnt <= r_stat_rsp_cnt + 32'd1;
      end
      if (w_rsp_illegal && (r_stat_err_cnt != 16'hFFFF)) begin
        r_stat_err_cnt <= r_stat_err_cnt + 16'd1;
      end
    end
  end

  assign stat_rsp_cnt = r_stat_rsp_cnt;
  assign stat_err_cnt = r_stat_err_cnt;
`else
  assign stat_rsp_cnt = 32'd0;
  assign stat_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bank_response_reorder.sv
// Bench for bank_response_reorder: directed scenarios plus random traffic against a queue-based model.
module tb_bank_response_reorder;
  localparam int AW = 32, BANKS = 8, BB = 3, DW = 32, DEPTH = 8, TB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          alloc_valid, rsp_valid, out_ready;
  logic [TB-1:0] rsp_tag;
  logic [BB-1:0] rsp_bank;
  logic [AW-BB-1:0] rsp_row;
  logic [DW-1:0] rsp_data;
  logic          alloc_ready, out_valid, err;
  logic [TB-1:0] alloc_tag, out_tag;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [31:0]   stat_rsp_cnt;
  logic [15:0]   stat_err_cnt;
  // plain-mapping instance sees the same stimulus
  logic          alloc_ready0, out_valid0, err0;
  logic [TB-1:0] alloc_tag0, out_tag0;
  logic [AW-1:0] out_addr0;
  logic [DW-1:0] out_data0;
  logic [31:0]   stat_rsp_cnt0;
  logic [15:0]   stat_err_cnt0;

  bank_response_reorder #(.ADDR_WIDTH(AW), .BANKS(BANKS), .SWIZZLE(1), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_bank(rsp_bank), .rsp_row(rsp_row), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_addr(out_addr), .out_data(out_data),
    .err(err), .stat_rsp_cnt(stat_rsp_cnt), .stat_err_cnt(stat_err_cnt));

  bank_response_reorder #(.ADDR_WIDTH(AW), .BANKS(BANKS), .SWIZZLE(0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready0), .alloc_tag(alloc_tag0),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_bank(rsp_bank), .rsp_row(rsp_row), .rsp_data(rsp_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_tag(out_tag0), .out_addr(out_addr0), .out_data(out_data0),
    .err(err0), .stat_rsp_cnt(stat_rsp_cnt0), .stat_err_cnt(stat_err_cnt0));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered queue of outstanding tags plus per-tag completion data.
  int          q_tags[$];
  int          m_next;
  bit          m_done [DEPTH];
  logic [AW-1:0] m_addr [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  bit          m_err;
  int          m_stat_rsp, m_stat_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_flight(input int t);
    foreach (q_tags[i]) if (q_tags[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_tags.delete();
    m_next = 0; m_err = 1'b0; m_stat_rsp = 0; m_stat_err = 0;
    for (int i = 0; i < DEPTH; i++) begin m_done[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q_tags.size() > 0) && m_done[q_tags[0]];
    check_val("alloc_ready", alloc_ready, q_tags.size() < DEPTH);
    check_val("alloc_tag", alloc_tag, m_next);
    check_val("out_valid", out_valid, ev);
    check_val("out_tag", out_tag, (q_tags.size() > 0) ? q_tags[0] : m_next);
    if (ev) begin
      check_val("out_addr", out_addr, m_addr[q_tags[0]]);
      check_val("out_data", out_data, m_data[q_tags[0]]);
    end
    check_val("err", err, m_err);
`ifdef BANK_RSP_STATS_EN
    check_val("stat_rsp_cnt", stat_rsp_cnt, m_stat_rsp);
    check_val("stat_err_cnt", stat_err_cnt, m_stat_err);
`else
    check_val("stat_rsp_cnt", stat_rsp_cnt, 0);
    check_val("stat_err_cnt", stat_err_cnt, 0);
`endif
  endtask

  // One clock: check current outputs, drive inputs, advance the model. lin is the linear address.
  task automatic step(input bit av, input bit rv, input int rtag, input logic [AW-1:0] lin,
                      input logic [DW-1:0] dat, input bit ordy);
    bit fire_a, legal, retire;
    check_outputs();
    alloc_valid = av; rsp_valid = rv; rsp_tag = rtag[TB-1:0];
    rsp_row  = lin[AW-1:BB];
    rsp_bank = lin[BB-1:0] ^ lin[2*BB-1:BB];
    rsp_data = dat; out_ready = ordy;
    fire_a = av && (q_tags.size() < DEPTH);
    legal  = rv && in_flight(rtag) && !m_done[rtag];
    retire = (q_tags.size() > 0) && m_done[q_tags[0]] && ordy;
    if (rv && !legal) begin
      m_err = 1'b1;
      if (m_stat_err < 16'hFFFF) m_stat_err++;
    end
    if (legal) begin m_done[rtag] = 1'b1; m_addr[rtag] = lin; m_data[rtag] = dat; end
    if (retire) begin m_done[q_tags[0]] = 1'b0; void'(q_tags.pop_front()); m_stat_rsp++; end
    if (fire_a) begin q_tags.push_back(m_next); m_next = (m_next + 1) % DEPTH; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, '0, 1'b0);
  endtask

  // Async reset applied between clock edges; outputs must change before any edge.
  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_alloc_ready", alloc_ready, 1);
    check_val("rst_alloc_tag", alloc_tag, 0);
    check_val("rst_err", err, 0);
    check_val("rst_out_tag", out_tag, 0);
    check_val("rst_out_addr", out_addr, 0);
    check_val("rst_out_data", out_data, 0);
    model_reset();
    alloc_valid = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
    rsp_tag = '0; rsp_bank = '0; rsp_row = '0; rsp_data = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int pick, cand[$];
    rst_n = 1'b1;
    alloc_valid = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
    rsp_tag = '0; rsp_bank = '0; rsp_row = '0; rsp_data = '0;
    model_reset();
    do_reset();

    // swizzle inverse: bank 1, row 2 -> 0x13
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 0, 32'h13, 32'hA5, 1'b0);
    check_val("swz_valid", out_valid, 1);
    check_val("swz_addr", out_addr, 32'h13);
    check_val("swz_data", out_data, 32'hA5);
    check_val("swz_bank_seen", rsp_bank, 1);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1);

    // reorder: respond 2,0,1; retire in 0,1,2 order
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 2, 32'h29, 32'h22, 1'b0);
    check_val("hol_wait", out_valid, 0);
    step(1'b0, 1'b1, 0, 32'h1000_0040, 32'h20, 1'b0);
    step(1'b0, 1'b1, 1, 32'h0000_0ABC, 32'h21, 1'b1);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1);
    check_val("reorder_tag2", out_tag, 2);
    check_val("reorder_addr2", out_addr, 32'h29);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1);

    // full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    check_val("full_ready", alloc_ready, 0);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 0, 32'h0000_0077, 32'h77, 1'b0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1);
    check_val("wrap_ready", alloc_ready, 1);
    check_val("wrap_tag", alloc_tag, 0);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);

    // errors: unallocated tag, then duplicate for a done tag
    do_reset();
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 5, 32'h55, 32'h55, 1'b0);
    check_val("err_unalloc", err, 1);
    step(1'b0, 1'b1, 0, 32'h11, 32'h11, 1'b0);
    step(1'b0, 1'b1, 0, 32'h22, 32'h22, 1'b0);
    idle(2);
    check_val("err_sticky", err, 1);
    check_val("err_data_kept", out_data, 32'h11);
`ifdef BANK_RSP_STATS_EN
    check_val("err_stat", stat_err_cnt, 2);
`endif

    // backpressure then mid-stream reset
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b0, 0, '0, '0, 1'b0);
      check_val("hold_addr", out_addr, 32'h11);
      check_val("hold_data", out_data, 32'h11);
    end
    do_reset();

    // plain mapping instance: bank 3, row 2 -> 0x13
    step(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 0, 32'h11, 32'h5A, 1'b0);
    check_val("noswz_bank", rsp_bank, 3);
    check_val("noswz_valid", out_valid0, 1);
    check_val("noswz_addr", out_addr0, 32'h13);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1);

    // random traffic, mostly legal responses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cand.delete();
      foreach (q_tags[i]) if (!m_done[q_tags[i]]) cand.push_back(q_tags[i]);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8) pick = cand[$urandom_range(0, cand.size() - 1)];
      else pick = $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, pick, $urandom, $urandom,
           $urandom_range(0, 3) != 0);
    end
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
